// File: rtl/sram_write_ctrl.sv
// sram_write_ctrl: turns single-bit write requests into a timed
// bitline-setup / one-hot wordline pulse / bitline-hold sequence for a
// small bitcell column. Every output is registered, so the wordline and
// the bitline/enable are never updated in the same cycle.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_valid while req_ready is 0 is ignored, and the
// requester must hold req_addr/req_data stable until the transfer happens.
module sram_write_ctrl #(
  parameter int ROWS      = 4,
  parameter int AW        = $clog2(ROWS),
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_addr,
  input  logic            req_data,
  output logic [ROWS-1:0] wwl,
  output logic            wbl,
  output logic            wbl_en,
  output logic            done,
  output logic            err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [AW:0] ROW_LIMIT = (AW+1)'(ROWS);
  localparam logic [7:0]  SETUP_LD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0]  PULSE_LD  = 8'(PULSE_CYC - 1);
  localparam logic [7:0]  HOLD_LD   = 8'(HOLD_CYC - 1);

  state_t          state_q, state_n;
  logic [7:0]      cnt_q, cnt_n;
  logic [AW-1:0]   addr_q, addr_n;
  logic            data_q, data_n;
  logic [ROWS-1:0] wwl_q, wwl_n;
  logic            wbl_q, wbl_n;
  logic            wbl_en_q, wbl_en_n;
  logic            done_q, done_n;
  logic            err_q, err_n;
  logic            ready_q, ready_n;
  logic [ROWS-1:0] row_sel;
  logic            accept;
  logic            in_range;

  assign req_ready = ready_q;
  assign wwl       = wwl_q;
  assign wbl       = wbl_q;
  assign wbl_en    = wbl_en_q;
  assign done      = done_q;
  assign err       = err_q;

  assign accept   = req_valid && ready_q;
  assign in_range = ({1'b0, req_addr} < ROW_LIMIT);

  // One-hot decode of the latched row address.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      row_sel[i] = (addr_q == AW'(i));
    end
  end

  // Next-state, phase counter and next registered output values.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    addr_n   = addr_q;
    data_n   = data_q;
    wwl_n    = '0;
    wbl_n    = wbl_q;
    wbl_en_n = wbl_en_q;
    done_n   = 1'b0;
    err_n    = 1'b0;

    case (state_q)
      IDLE: begin
        wbl_en_n = 1'b0;
        if (accept) begin
          addr_n = req_addr;
          data_n = req_data;
          if (in_range) begin
            state_n  = SETUP;
            cnt_n    = SETUP_LD;
            wbl_n    = req_data;
            wbl_en_n = 1'b1;
          end else begin
            // Out-of-range row: report and stay idle, column untouched.
            done_n = 1'b1;
            err_n  = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt_q == 8'd0) begin
          state_n = PULSE;
          cnt_n   = PULSE_LD;
          wwl_n   = row_sel;
        end else begin
          cnt_n = cnt_q - 8'd1;
        end
      end
      PULSE: begin
        if (cnt_q == 8'd0) begin
          state_n = HOLD;
          cnt_n   = HOLD_LD;
        end else begin
          cnt_n = cnt_q - 8'd1;
          wwl_n = row_sel;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_n  = IDLE;
          cnt_n    = 8'd0;
          wbl_en_n = 1'b0;
          done_n   = 1'b1;
        end else begin
          cnt_n = cnt_q - 8'd1;
        end
      end
      default: begin
        state_n  = IDLE;
        cnt_n    = 8'd0;
        wbl_en_n = 1'b0;
      end
    endcase

    ready_n = (state_n == IDLE);
  end

  // State, counter and registered outputs; reset drops everything at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      addr_q   <= '0;
      data_q   <= 1'b0;
      wwl_q    <= '0;
      wbl_q    <= 1'b0;
      wbl_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      addr_q   <= addr_n;
      data_q   <= data_n;
      wwl_q    <= wwl_n;
      wbl_q    <= wbl_n;
      wbl_en_q <= wbl_en_n;
      done_q   <= done_n;
      err_q    <= err_n;
      ready_q  <= ready_n;
    end
  end

endmodule

// File: tb/tb_sram_write_ctrl.sv
// Directed testbench for sram_write_ctrl. Three instances: defaults,
// ROWS=3 (for the out-of-range path) and SETUP=3/PULSE=1/HOLD=2.
// Cycle k is observed 1 time unit after the rising edge that starts it;
// a request driven during cycle 0 is accepted at the edge ending it.
module tb_sram_write_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Instance 0: default parameters
  logic       v0, d0, rdy0, wbl0, en0, done0, err0;
  logic [1:0] a0;
  logic [3:0] wwl0;
  // Instance 1: ROWS=3
  logic       v1, d1, rdy1, wbl1, en1, done1, err1;
  logic [1:0] a1;
  logic [2:0] wwl1;
  // Instance 2: SETUP_CYC=3, PULSE_CYC=1, HOLD_CYC=2
  logic       v2, d2, rdy2, wbl2, en2, done2, err2;
  logic [1:0] a2;
  logic [3:0] wwl2;

  int checks = 0;
  int errors = 0;

  sram_write_ctrl u0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_addr(a0),
    .req_data(d0), .wwl(wwl0), .wbl(wbl0), .wbl_en(en0), .done(done0), .err(err0)
  );

  sram_write_ctrl #(.ROWS(3)) u1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_addr(a1),
    .req_data(d1), .wwl(wwl1), .wbl(wbl1), .wbl_en(en1), .done(done1), .err(err1)
  );

  sram_write_ctrl #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) u2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .req_addr(a2),
    .req_data(d2), .wwl(wwl2), .wbl(wbl2), .wbl_en(en2), .done(done2), .err(err2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Vector layout for 4-row instances: {wwl[3:0], wbl, wbl_en, done, err, req_ready}
  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({wwl0, wbl0, en0, done0, err0, rdy0} !== 9'b0) begin
      errors++;
      $display("FAIL reset_u0 got %b expected %b", {wwl0, wbl0, en0, done0, err0, rdy0}, 9'b0);
    end
    checks++;
    if ({wwl1, wbl1, en1, done1, err1, rdy1} !== 8'b0) begin
      errors++;
      $display("FAIL reset_u1 got %b expected %b", {wwl1, wbl1, en1, done1, err1, rdy1}, 8'b0);
    end
    checks++;
    if ({wwl2, wbl2, en2, done2, err2, rdy2} !== 9'b0) begin
      errors++;
      $display("FAIL reset_u2 got %b expected %b", {wwl2, wbl2, en2, done2, err2, rdy2}, 9'b0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({rdy0, rdy1, rdy2} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_ready got %b expected %b", {rdy0, rdy1, rdy2}, 3'b111);
    end
  endtask

  task automatic test_basic;
    logic [8:0] exp_v [6];
    exp_v = '{9'b0000_1_1_0_0_0, 9'b0100_1_1_0_0_0, 9'b0100_1_1_0_0_0,
              9'b0000_1_1_0_0_0, 9'b0000_1_0_1_0_1, 9'b0000_1_0_0_0_1};
    v0 = 1'b1; a0 = 2'd2; d0 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) v0 = 1'b0;
      checks++;
      if ({wwl0, wbl0, en0, done0, err0, rdy0} !== exp_v[c-1]) begin
        errors++;
        $display("FAIL basic_c%0d got %b expected %b", c, {wwl0, wbl0, en0, done0, err0, rdy0}, exp_v[c-1]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] exp_v [11];
    exp_v = '{9'b0000_0_1_0_0_0, 9'b0001_0_1_0_0_0, 9'b0001_0_1_0_0_0,
              9'b0000_0_1_0_0_0, 9'b0000_0_0_1_0_1, 9'b0000_1_1_0_0_0,
              9'b1000_1_1_0_0_0, 9'b1000_1_1_0_0_0, 9'b0000_1_1_0_0_0,
              9'b0000_1_0_1_0_1, 9'b0000_1_0_0_0_1};
    v0 = 1'b1; a0 = 2'd0; d0 = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 1) begin
        a0 = 2'd3; d0 = 1'b1;   // second request waits with valid held high
      end
      checks++;
      if ({wwl0, wbl0, en0, done0, err0, rdy0} !== exp_v[c-1]) begin
        errors++;
        $display("FAIL b2b_c%0d got %b expected %b", c, {wwl0, wbl0, en0, done0, err0, rdy0}, exp_v[c-1]);
      end
      checks++;
      if ($countones(wwl0) > 1) begin
        errors++;
        $display("FAIL b2b_onehot_c%0d got %b expected at most one bit", c, wwl0);
      end
      if (c == 6) v0 = 1'b0;
    end
  endtask

  task automatic test_hold_valid;
    logic [8:0] exp_v [6];
    exp_v = '{9'b0000_1_1_0_0_0, 9'b0010_1_1_0_0_0, 9'b0010_1_1_0_0_0,
              9'b0000_1_1_0_0_0, 9'b0000_1_0_1_0_1, 9'b0000_1_0_0_0_1};
    v0 = 1'b1; a0 = 2'd1; d0 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      checks++;
      if ({wwl0, wbl0, en0, done0, err0, rdy0} !== exp_v[c-1]) begin
        errors++;
        $display("FAIL hold_valid_c%0d got %b expected %b", c, {wwl0, wbl0, en0, done0, err0, rdy0}, exp_v[c-1]);
      end
      if (c < 4) a0 = 2'(c + 1);
      if (c == 4) v0 = 1'b0;
    end
  endtask

  // Vector layout for instance 1: {wwl[2:0], wbl, wbl_en, done, err, req_ready}
  task automatic test_error;
    logic [7:0] exp_v [5];
    exp_v = '{8'b000_1_1_0_0_0, 8'b100_1_1_0_0_0, 8'b100_1_1_0_0_0,
              8'b000_1_1_0_0_0, 8'b000_1_0_1_0_1};
    v1 = 1'b1; a1 = 2'd3; d1 = 1'b1;
    tick();
    v1 = 1'b0;
    checks++;
    if ({wwl1, wbl1, en1, done1, err1, rdy1} !== 8'b000_0_0_1_1_1) begin
      errors++;
      $display("FAIL error_c1 got %b expected %b", {wwl1, wbl1, en1, done1, err1, rdy1}, 8'b000_0_0_1_1_1);
    end
    tick();
    checks++;
    if ({wwl1, wbl1, en1, done1, err1, rdy1} !== 8'b000_0_0_0_0_1) begin
      errors++;
      $display("FAIL error_c2 got %b expected %b", {wwl1, wbl1, en1, done1, err1, rdy1}, 8'b000_0_0_0_0_1);
    end
    // highest legal row on the 3-row instance still writes normally
    v1 = 1'b1; a1 = 2'd2; d1 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) v1 = 1'b0;
      checks++;
      if ({wwl1, wbl1, en1, done1, err1, rdy1} !== exp_v[c-1]) begin
        errors++;
        $display("FAIL last_row_c%0d got %b expected %b", c, {wwl1, wbl1, en1, done1, err1, rdy1}, exp_v[c-1]);
      end
    end
  endtask

  task automatic test_timing;
    logic [8:0] exp_v [8];
    exp_v = '{9'b0000_1_1_0_0_0, 9'b0000_1_1_0_0_0, 9'b0000_1_1_0_0_0,
              9'b0010_1_1_0_0_0, 9'b0000_1_1_0_0_0, 9'b0000_1_1_0_0_0,
              9'b0000_1_0_1_0_1, 9'b0000_1_0_0_0_1};
    v2 = 1'b1; a2 = 2'd1; d2 = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) v2 = 1'b0;
      checks++;
      if ({wwl2, wbl2, en2, done2, err2, rdy2} !== exp_v[c-1]) begin
        errors++;
        $display("FAIL timing_c%0d got %b expected %b", c, {wwl2, wbl2, en2, done2, err2, rdy2}, exp_v[c-1]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [8:0] exp_v [5];
    exp_v = '{9'b0000_0_1_0_0_0, 9'b1000_0_1_0_0_0, 9'b1000_0_1_0_0_0,
              9'b0000_0_1_0_0_0, 9'b0000_0_0_1_0_1};
    v0 = 1'b1; a0 = 2'd1; d0 = 1'b1;
    tick();
    v0 = 1'b0;
    tick();
    checks++;
    if (wwl0 !== 4'b0010) begin
      errors++;
      $display("FAIL rst_mid_pulse got %b expected %b", wwl0, 4'b0010);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({wwl0, en0, done0, rdy0} !== 7'b0000_0_0_0) begin
      errors++;
      $display("FAIL rst_mid_drop got %b expected %b", {wwl0, en0, done0, rdy0}, 7'b0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({wwl0, en0, done0, rdy0} !== 7'b0000_0_0_1) begin
      errors++;
      $display("FAIL rst_mid_release got %b expected %b", {wwl0, en0, done0, rdy0}, 7'b0000_0_0_1);
    end
    tick();
    checks++;
    if ({wwl0, en0, done0, rdy0} !== 7'b0000_0_0_1) begin
      errors++;
      $display("FAIL rst_mid_no_done got %b expected %b", {wwl0, en0, done0, rdy0}, 7'b0000_0_0_1);
    end
    v0 = 1'b1; a0 = 2'd3; d0 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) v0 = 1'b0;
      checks++;
      if ({wwl0, wbl0, en0, done0, err0, rdy0} !== exp_v[c-1]) begin
        errors++;
        $display("FAIL rst_mid_rewrite_c%0d got %b expected %b", c, {wwl0, wbl0, en0, done0, err0, rdy0}, exp_v[c-1]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    v0 = 1'b0; a0 = '0; d0 = 1'b0;
    v1 = 1'b0; a1 = '0; d1 = 1'b0;
    v2 = 1'b0; a2 = '0; d2 = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_hold_valid();
    test_error();
    test_timing();
    test_reset_mid();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
